morra_player: RTL and testbench
===============================

# morra_player

Stimulus-side counterpart of the `MorraCinese` game FSMD. It generates legal move pairs for two pseudo-random players and drives `PRIMO`, `SECONDO` and `INIZIO` into the game. It consumes `MANCHE` and `PARTITA`, keeps per-match tallies and reports the match outcome. It sits in front of the game core for self-running demos and for closed-loop cross-checks against the game.

## Interface
- `SEED1`, default 8'hA5: reset seed of player-1 LFSR. A value of 0 is replaced by 8'h01.
- `SEED2`, default 8'h3C: reset seed of player-2 LFSR. A value of 0 is replaced by 8'h01.
- `MAX_MANCHE`, default 19: manches issued before a timeout.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `START`  in  1  begins a match when sampled high in IDLE.
- `STOP`  in  1  aborts the match; returns to IDLE next cycle.
- `PRIMO`  out  2  player-1 move to the game.
- `SECONDO`  out  2  player-2 move to the game.
- `INIZIO`  out  1  match-start strobe to the game.
- `MANCHE`  in  2  round result from the game.
- `PARTITA`  in  2  match result from the game.
- `WINS1`, `WINS2`, `DRAWS`  out  8 each  round tallies for the current match.
- `RESULT`  out  2  final `PARTITA` value latched at match end.
- `BUSY`  out  1  high while a match is in progress.
- `DONE`  out  1  one-cycle pulse at match end.
- `ERR`  out  1  sticky flag: illegal result seen or timeout. Cleared by `rst` or `START`.

## Operation
- Move encoding: 00 none/invalid, 01 sasso, 10 carta, 11 forbice.
- MANCHE/PARTITA encoding: 00 invalid/ongoing, 01 player 1, 10 player 2, 11 draw.
- States are IDLE, INIT, INIT_WAIT, ISSUE, SAMPLE and FINISH.
- IDLE: all game outputs are 00/0. `START`=1 clears the counters, `RESULT` and `ERR`, then moves to INIT.
- INIT: drives `INIZIO`=1 with `PRIMO`=`SECONDO`=00 for one cycle, then moves to INIT_WAIT.
- INIT_WAIT: one cycle. The game output is ignored. Clears the last-winner memory, then moves to ISSUE.
- ISSUE: each LFSR steps once. The candidate move is lfsr[1:0], with 00 mapped to 01.
  - If that player won the previous manche and the candidate equals their winning move, the move is rotated 01→10→11→01.
  - The resulting moves are driven and held through SAMPLE. The manche counter increments.
- SAMPLE: `MANCHE` is evaluated first.
  - 01 → `WINS1`+1 and record (P1, `PRIMO`).
  - 10 → `WINS2`+1 and record (P2, `SECONDO`).
  - 11 → `DRAWS`+1 and clear the record.
  - 00 → set `ERR`; counters and record unchanged.
  - Then, if `PARTITA`≠00, latch `RESULT` and go to FINISH.
  - Otherwise, if the manche count equals `MAX_MANCHE`, set `ERR`, keep `RESULT`=00 and go to FINISH.
  - Otherwise go to ISSUE.
- FINISH: `DONE`=1 for one cycle, then IDLE. Counters and `RESULT` hold until the next `START`.
- Counters saturate at 255.
- LFSRs are 8-bit Galois with polynomial x^8+x^6+x^5+x^4+1 (mask 8'hB8). They advance only in ISSUE.
- `STOP` in any non-IDLE state goes to IDLE next cycle. No `DONE` pulse; counters hold. `STOP` takes priority over all other transitions.
- `START` outside IDLE is ignored.

## Timing
- Reset values:
  - `PRIMO`=`SECONDO`=00, `INIZIO`=0.
  - `WINS1`=`WINS2`=`DRAWS`=0, `RESULT`=00.
  - `BUSY`=`DONE`=`ERR`=0.
  - LFSRs equal their seeds; state is IDLE.
- All outputs are registered. Reset mid-match forces the reset values immediately, independent of `clk`.
- The game registers its inputs on the edge ending ISSUE (or INIT). `MANCHE`/`PARTITA` for that move are valid during the following cycle (SAMPLE or INIT_WAIT) and are sampled at its closing edge.
- Match latency: 2 cycles of setup, then 2 cycles per manche. `START`→`BUSY` takes 1 cycle.
- `BUSY` is high from INIT through FINISH inclusive. It is low in the cycle after the `DONE` pulse.
- Moves are stable for the whole ISSUE+SAMPLE window.

## Structure
- `morra_pkg` holds:
  - move localparams (NONE, SASSO, CARTA, FORBICE);
  - result codes (INVALID, P1, P2, DRAW);
  - the state enum;
  - the LFSR mask 8'hB8.
- One sub-module, `morra_lfsr`, instantiated twice. Its ports are `clk`, `rst`, `en`, SEED parameter and `q[7:0]`.

## Test plan
- Pulse `rst` during SAMPLE with `WINS1`=3 → in the same cycle all outputs return to reset values, the state is IDLE and the LFSRs are reloaded with their seeds.
- `START`, with the game stub answering `MANCHE`=01 to move `PRIMO`=10 → `WINS1`=1. The next ISSUE drives `PRIMO`∈{01,11}, never 10.
- Game stub returns `PARTITA`=10 in the 4th SAMPLE → `RESULT`=10 and `DONE` high for exactly 1 cycle, 2 cycles after that ISSUE. `BUSY`=0 on the next cycle.
- Game stub returns `MANCHE`=00 once → `ERR`=1 and stays 1, counters unchanged, the match continues. The next `START` clears `ERR`.
- `MAX_MANCHE`=3 with the stub always returning `PARTITA`=00 → after the 3rd SAMPLE, `ERR`=1, `RESULT`=00 and `DONE` pulses.
- `STOP` asserted in ISSUE → IDLE next cycle, `PRIMO`=`SECONDO`=00, no `DONE`; `SEED1`=0 → LFSR state is 8'h01 after reset.

Source files
------------

// File: rtl/morra_pkg.sv
// morra_pkg: shared definitions for the morra stimulus player.
//   - move codes driven on PRIMO/SECONDO
//   - result codes read from MANCHE/PARTITA
//   - player FSM state enum
//   - LFSR feedback mask plus step / move-selection / saturation helpers
package morra_pkg;

  // Move encoding
  localparam logic [1:0] NONE    = 2'b00;
  localparam logic [1:0] SASSO   = 2'b01;
  localparam logic [1:0] CARTA   = 2'b10;
  localparam logic [1:0] FORBICE = 2'b11;

  // MANCHE / PARTITA encoding
  localparam logic [1:0] INVALID = 2'b00;
  localparam logic [1:0] P1      = 2'b01;
  localparam logic [1:0] P2      = 2'b10;
  localparam logic [1:0] DRAW    = 2'b11;

  // Galois feedback for x^8+x^6+x^5+x^4+1 (right-shifting form)
  localparam logic [7:0] LFSR_MASK = 8'hB8;

  typedef enum logic [2:0] {
    IDLE, INIT, INIT_WAIT, ISSUE, SAMPLE, FINISH
  } state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
  endfunction

  // Move for the coming manche: low bits of the LFSR value after its step,
  // 00 promoted to sasso, rotated if it would repeat this player's last win.
  function automatic logic [1:0] pick_move(input logic [7:0] q,
                                           input logic       won,
                                           input logic [1:0] last);
    logic [1:0] m;
    m = 2'(lfsr_step(q));
    if (m == NONE) m = SASSO;
    if (won && (m == last)) m = (m == FORBICE) ? SASSO : (m + 2'd1);
    return m;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/morra_lfsr.sv
// morra_lfsr: 8-bit Galois LFSR used as a pseudo-random move source.
//   clk  in   clock
//   rst  in   async active-high reset, loads SEED (0 replaced by 8'h01)
//   en   in   advance one step on this clock edge
//   q    out  current register value
module morra_lfsr
  import morra_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  // An all-zero state would lock the LFSR up.
  localparam logic [7:0] SEED_FIX = (SEED == 8'h00) ? 8'h01 : SEED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= SEED_FIX;
    else if (en) q <= lfsr_step(q);
  end

endmodule

// File: rtl/morra_player.sv
// morra_player: drives two pseudo-random players into the morra game core
// and keeps per-match tallies.
//   START/STOP         in   begin a match from IDLE / abort to IDLE
//   PRIMO/SECONDO      out  player moves (held for ISSUE+SAMPLE)
//   INIZIO             out  match-start strobe to the game
//   MANCHE/PARTITA     in   round / match result from the game
//   WINS1/WINS2/DRAWS  out  saturating round tallies
//   RESULT             out  latched final PARTITA
//   BUSY/DONE/ERR      out  match in progress / end pulse / sticky error
module morra_player
  import morra_pkg::*;
#(
  parameter logic [7:0]  SEED1      = 8'hA5,
  parameter logic [7:0]  SEED2      = 8'h3C,
  parameter int unsigned MAX_MANCHE = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       START,
  input  logic       STOP,
  output logic [1:0] PRIMO,
  output logic [1:0] SECONDO,
  output logic       INIZIO,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  output logic [7:0] WINS1,
  output logic [7:0] WINS2,
  output logic [7:0] DRAWS,
  output logic [1:0] RESULT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [7:0] MAX_M = MAX_MANCHE[7:0];

  state_t     state_reg, state_next;
  logic [7:0] lfsr1_q, lfsr2_q;
  logic       lfsr_en;
  logic       abort;

  logic [7:0] wins1_reg, wins1_next, wins2_reg, wins2_next, draws_reg, draws_next;
  logic [7:0] manche_reg, manche_next;
  logic [1:0] result_reg, result_next;
  logic       err_reg, err_next;
  logic [1:0] win_reg, win_next;       // last manche winner (P1/P2) or INVALID
  logic [1:0] wmove_reg, wmove_next;   // that winner's move
  logic [1:0] primo_reg, primo_next, secondo_reg, secondo_next;
  logic       inizio_reg, inizio_next, busy_reg, busy_next, done_reg, done_next;

  assign abort   = STOP && (state_reg != IDLE);
  assign lfsr_en = (state_reg == ISSUE) && !abort;

  morra_lfsr #(.SEED(SEED1)) u_lfsr1 (.clk(clk), .rst(rst), .en(lfsr_en), .q(lfsr1_q));
  morra_lfsr #(.SEED(SEED2)) u_lfsr2 (.clk(clk), .rst(rst), .en(lfsr_en), .q(lfsr2_q));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:      if (START) state_next = INIT;
        INIT:      state_next = INIT_WAIT;
        INIT_WAIT: state_next = ISSUE;
        ISSUE:     state_next = SAMPLE;
        SAMPLE:    state_next = ((PARTITA != INVALID) || (manche_reg == MAX_M)) ? FINISH : ISSUE;
        FINISH:    state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Output / datapath next values. Every output is registered, so the
  // game-facing signals are derived from the state being entered.
  always_comb begin
    wins1_next  = wins1_reg;
    wins2_next  = wins2_reg;
    draws_next  = draws_reg;
    manche_next = manche_reg;
    result_next = result_reg;
    err_next    = err_reg;
    win_next    = win_reg;
    wmove_next  = wmove_reg;
    if (!abort) begin
      case (state_reg)
        IDLE: if (START) begin
          wins1_next  = 8'd0;
          wins2_next  = 8'd0;
          draws_next  = 8'd0;
          manche_next = 8'd0;
          result_next = INVALID;
          err_next    = 1'b0;
        end
        INIT_WAIT: win_next = INVALID;
        ISSUE:     manche_next = sat_inc(manche_reg);
        SAMPLE: begin
          case (MANCHE)
            P1: begin
              wins1_next = sat_inc(wins1_reg);
              win_next   = P1;
              wmove_next = primo_reg;
            end
            P2: begin
              wins2_next = sat_inc(wins2_reg);
              win_next   = P2;
              wmove_next = secondo_reg;
            end
            DRAW: begin
              draws_next = sat_inc(draws_reg);
              win_next   = INVALID;
            end
            default: err_next = 1'b1;
          endcase
          if (PARTITA != INVALID)        result_next = PARTITA;
          else if (manche_reg == MAX_M)  err_next    = 1'b1;
        end
        default: ;
      endcase
    end

    inizio_next  = (state_next == INIT);
    busy_next    = (state_next != IDLE);
    done_next    = (state_next == FINISH);
    primo_next   = NONE;
    secondo_next = NONE;
    if (state_next == ISSUE) begin
      // Uses the winner record as updated by the SAMPLE closing this edge.
      primo_next   = pick_move(lfsr1_q, win_next == P1, wmove_next);
      secondo_next = pick_move(lfsr2_q, win_next == P2, wmove_next);
    end else if (state_next == SAMPLE) begin
      primo_next   = primo_reg;
      secondo_next = secondo_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wins1_reg   <= 8'd0;
      wins2_reg   <= 8'd0;
      draws_reg   <= 8'd0;
      manche_reg  <= 8'd0;
      result_reg  <= INVALID;
      err_reg     <= 1'b0;
      win_reg     <= INVALID;
      wmove_reg   <= NONE;
      primo_reg   <= NONE;
      secondo_reg <= NONE;
      inizio_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      wins1_reg   <= wins1_next;
      wins2_reg   <= wins2_next;
      draws_reg   <= draws_next;
      manche_reg  <= manche_next;
      result_reg  <= result_next;
      err_reg     <= err_next;
      win_reg     <= win_next;
      wmove_reg   <= wmove_next;
      primo_reg   <= primo_next;
      secondo_reg <= secondo_next;
      inizio_reg  <= inizio_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign PRIMO   = primo_reg;
  assign SECONDO = secondo_reg;
  assign INIZIO  = inizio_reg;
  assign WINS1   = wins1_reg;
  assign WINS2   = wins2_reg;
  assign DRAWS   = draws_reg;
  assign RESULT  = result_reg;
  assign BUSY    = busy_reg;
  assign DONE    = done_reg;
  assign ERR     = err_reg;

endmodule

// File: tb/tb_morra_player.sv
// tb_morra_player: directed bench for morra_player. The bench plays the game
// stub itself, driving MANCHE/PARTITA by hand. Expected moves come from the
// LFSR sequences worked out by hand from the seeds:
//   seed A5 -> EA(10) 75(01) 82(10) 41(01)
//   seed 3C -> 1E(10) 0F(11) BF(11) E7(11)
//   seed 00 -> 01 -> B8(00, promoted to 01)
module tb_morra_player;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // Instance 1: default parameters
  logic       start, stop;
  logic [1:0] manche, partita;
  logic [1:0] primo, secondo, result;
  logic       inizio, busy, done, err;
  logic [7:0] wins1, wins2, draws;

  // Instance 2: zero seed, short timeout
  logic       start2, stop2;
  logic [1:0] manche2, partita2;
  logic [1:0] primo2, secondo2, result2;
  logic       inizio2, busy2, done2, err2;
  logic [7:0] wins1_2, wins2_2, draws2;

  morra_player dut (
    .clk(clk), .rst(rst), .START(start), .STOP(stop),
    .PRIMO(primo), .SECONDO(secondo), .INIZIO(inizio),
    .MANCHE(manche), .PARTITA(partita),
    .WINS1(wins1), .WINS2(wins2), .DRAWS(draws), .RESULT(result),
    .BUSY(busy), .DONE(done), .ERR(err)
  );

  morra_player #(.SEED1(8'h00), .MAX_MANCHE(3)) dut2 (
    .clk(clk), .rst(rst), .START(start2), .STOP(stop2),
    .PRIMO(primo2), .SECONDO(secondo2), .INIZIO(inizio2),
    .MANCHE(manche2), .PARTITA(partita2),
    .WINS1(wins1_2), .WINS2(wins2_2), .DRAWS(draws2), .RESULT(result2),
    .BUSY(busy2), .DONE(done2), .ERR(err2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s = %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 0; stop = 0; manche = 2'b00; partita = 2'b00;
    start2 = 0; stop2 = 0; manche2 = 2'b00; partita2 = 2'b00;
    #12;
    // ---- reset state ----
    chk("rst_primo",   primo,   2'b00);
    chk("rst_secondo", secondo, 2'b00);
    chk("rst_inizio",  inizio,  1'b0);
    chk("rst_wins1",   wins1,   8'd0);
    chk("rst_busy",    busy,    1'b0);
    chk("rst_done",    done,    1'b0);
    chk("rst_err",     err,     1'b0);
    chk("rst_result",  result,  2'b00);
    chk("rst_lfsr1",   dut.u_lfsr1.q,  8'hA5);
    chk("rst_lfsr2",   dut.u_lfsr2.q,  8'h3C);
    chk("rst_seed0",   dut2.u_lfsr1.q, 8'h01);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 1'b0);

    // ---- match A: winner rotation and PARTITA end ----
    start = 1; tick(); start = 0;
    chk("a_init_busy",   busy,   1'b1);
    chk("a_init_inizio", inizio, 1'b1);
    chk("a_init_primo",  primo,  2'b00);
    tick();
    chk("a_wait_inizio", inizio, 1'b0);
    tick();                                   // ISSUE 1
    chk("a_m1_primo",   primo,   2'b10);
    chk("a_m1_secondo", secondo, 2'b10);
    manche = 2'b01;
    tick();                                   // SAMPLE 1
    chk("a_s1_primo_hold", primo, 2'b10);
    tick();                                   // ISSUE 2
    chk("a_m2_wins1",   wins1,   8'd1);
    chk("a_m2_primo",   primo,   2'b01);
    chk("a_m2_secondo", secondo, 2'b11);
    manche = 2'b10;
    tick(); tick();                           // ISSUE 3
    chk("a_m3_wins2",   wins2,   8'd1);
    chk("a_m3_primo",   primo,   2'b10);
    chk("a_m3_secondo_rot", secondo, 2'b01);
    manche = 2'b11;
    tick(); tick();                           // ISSUE 4
    chk("a_m4_draws",   draws,   8'd1);
    chk("a_m4_primo",   primo,   2'b01);
    chk("a_m4_secondo", secondo, 2'b11);
    manche = 2'b10; partita = 2'b10;
    tick();                                   // SAMPLE 4
    chk("a_s4_done", done, 1'b0);
    tick();                                   // FINISH
    manche = 2'b00; partita = 2'b00;
    chk("a_fin_done",   done,   1'b1);
    chk("a_fin_busy",   busy,   1'b1);
    chk("a_fin_result", result, 2'b10);
    chk("a_fin_wins2",  wins2,  8'd2);
    chk("a_fin_err",    err,    1'b0);
    tick();                                   // IDLE
    chk("a_idle_done",   done,   1'b0);
    chk("a_idle_busy",   busy,   1'b0);
    chk("a_idle_wins2",  wins2,  8'd2);
    chk("a_idle_result", result, 2'b10);

    // ---- match C: invalid MANCHE, then STOP in ISSUE ----
    start = 1; tick(); start = 0;
    chk("c_init_wins2",  wins2,  8'd0);
    chk("c_init_result", result, 2'b00);
    tick(); tick();                           // ISSUE 1
    manche = 2'b00;
    tick(); tick();                           // ISSUE 2
    chk("c_err_set",   err,   1'b1);
    chk("c_err_wins1", wins1, 8'd0);
    chk("c_err_draws", draws, 8'd0);
    chk("c_err_busy",  busy,  1'b1);
    manche = 2'b01;
    tick(); tick();                           // ISSUE 3
    chk("c_m3_wins1", wins1, 8'd1);
    chk("c_err_sticky", err, 1'b1);
    stop = 1; tick(); stop = 0;               // IDLE
    manche = 2'b00;
    chk("c_stop_busy",    busy,    1'b0);
    chk("c_stop_primo",   primo,   2'b00);
    chk("c_stop_secondo", secondo, 2'b00);
    chk("c_stop_done",    done,    1'b0);
    chk("c_stop_wins1",   wins1,   8'd1);
    tick();
    chk("c_stop_nodone", done, 1'b0);
    start = 1; tick(); start = 0;             // INIT
    chk("c_restart_err",   err,   1'b0);
    chk("c_restart_wins1", wins1, 8'd0);
    stop = 1; tick(); stop = 0;
    chk("c_stop_init_busy", busy, 1'b0);

    // ---- match B: async reset during SAMPLE ----
    start = 1; tick(); start = 0;
    tick(); tick();                           // ISSUE 1
    manche = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick(); tick();
    end                                       // ISSUE 4
    tick();                                   // SAMPLE 4
    chk("b_s4_wins1", wins1, 8'd3);
    chk("b_s4_busy",  busy,  1'b1);
    #2 rst = 1'b1;
    #1;
    chk("b_rst_wins1", wins1, 8'd0);
    chk("b_rst_busy",  busy,  1'b0);
    chk("b_rst_primo", primo, 2'b00);
    chk("b_rst_lfsr1", dut.u_lfsr1.q, 8'hA5);
    chk("b_rst_lfsr2", dut.u_lfsr2.q, 8'h3C);
    rst = 1'b0;
    manche = 2'b00;
    tick();
    chk("b_post_busy", busy, 1'b0);
    chk("b_post_done", done, 1'b0);

    // ---- dut2: zero seed and MAX_MANCHE timeout ----
    start2 = 1; tick(); start2 = 0;
    tick(); tick();                           // ISSUE 1
    chk("t_m1_primo", primo2, 2'b01);
    manche2 = 2'b11;
    tick(); tick(); tick(); tick(); tick();   // SAMPLE 3
    chk("t_s3_done", done2, 1'b0);
    chk("t_s3_err",  err2,  1'b0);
    tick();                                   // FINISH
    manche2 = 2'b00;
    chk("t_fin_err",    err2,    1'b1);
    chk("t_fin_done",   done2,   1'b1);
    chk("t_fin_result", result2, 2'b00);
    chk("t_fin_draws",  draws2,  8'd3);
    tick();
    chk("t_idle_busy", busy2, 1'b0);
    chk("t_idle_done", done2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
